depth_event_normalizer: RTL and testbench
=========================================

// Module: depth_event_normalizer
// PURPOSE
//  Multi-symbol successor of the single-symbol depth parser. Sits between event_record_unpack and the
//  book-update engine. Maps unpacked records to binance_depth_types::depth_event_t and keeps one
//  sequence-sync state machine per symbol: drops deltas seen before a snapshot, drops stale deltas,
//  and flags gaps. Buffers output in a FIFO with valid/ready backpressure on both sides.
// PARAMETERS
//  NUM_SYMBOLS  4   symbols tracked; legal in_symbol range is 0..NUM_SYMBOLS-1
//  FIFO_DEPTH   8   output FIFO entries; must be a power of 2 and >= 2
//  CNT_W        32  width of the statistics counters
// PORTS
//  clk          in   1    single clock
//  rst_n        in   1    asynchronous, active-low reset
//  in_valid     in   1    input record valid
//  in_ready     out  1    block can accept a record; equals FIFO not full
//  in_ts_ns     in   64   receive timestamp
//  in_update_id in   64   exchange update id
//  in_symbol    in   16   symbol index
//  in_rec_type  in   8    0 = delta, 1 = snapshot, any other value is illegal
//  in_side      in   8    bit0: 1 = ASK, 0 = BID; bits 7:1 ignored
//  in_price_f32 in   32   price, passed through unchanged
//  in_qty_f32   in   32   quantity, passed through unchanged
//  sync_clr     in   1    pulse: every symbol goes to UNSYNCED
//  out_valid    out  1    FIFO head valid
//  out_ready    in   1    consumer accepts the head
//  depth_ev     out  depth_event_t  FIFO head; value is undefined while out_valid=0
//  synced       out  NUM_SYMBOLS   per-symbol SYNCED state
//  gap_pulse    out  1    one-cycle pulse when an accepted delta is classified as a gap
//  stat_accept  out  CNT_W  count of records written to the FIFO
//  stat_drop    out  CNT_W  count of records accepted on the input but discarded
//  stat_gap     out  CNT_W  count of gaps
// BEHAVIOUR
//  Reset: FIFO empty; out_valid=0; depth_ev=0; in_ready=1; synced=0; gap_pulse=0; all stats=0.
//  Handshake: a record is accepted when in_valid && in_ready. in_ready is registered and equals !full.
//   When the FIFO is full, a pop does not raise in_ready until the next cycle.
//  Classification is combinational on the accepted record, using the per-symbol table {state, last_uid}:
//   - in_symbol >= NUM_SYMBOLS, or illegal rec_type -> drop.
//   - SNAPSHOT -> emit with rec_type=REC_TYPE_SNAPSHOT and flags[FLAG_SNAP]=1; last_uid<=id;
//     state<=SYNCED.
//   - DELTA while UNSYNCED -> drop.
//   - DELTA while SYNCED:
//       id < last_uid -> drop (stale).
//       id == last_uid or id == last_uid+1 -> emit; last_uid<=id.
//       id > last_uid+1 -> emit with flags[FLAG_GAP]=1; gap_pulse=1; state<=UNSYNCED; last_uid<=id.
//  id comparisons are 64-bit unsigned. last_uid+1 wraps modulo 2^64, so last_uid = all-ones accepts id 0.
//  Emitted event: side from in_side[0]; symbol_id=in_symbol; ts_rx_ns, update_id, price_fp and qty_fp
//   are passed through; all other flag bits are 0.
//  Table update and FIFO write happen on the acceptance edge. Back-to-back records for the same symbol
//   see the updated table; no bubble is inserted.
//  Latency: accept at edge N -> out_valid=1 after edge N when the FIFO was empty. Output order equals
//   acceptance order.
//  Push and pop in the same cycle are both legal; the count is unchanged.
//  Output hold: while out_valid && !out_ready, depth_ev and out_valid stay stable.
//  sync_clr in the same cycle as a SNAPSHOT accept: sync_clr wins, so the symbol stays UNSYNCED, but the
//   event is still emitted.
//  Reset asserted mid-stream: FIFO contents are discarded and all state returns to the reset values.
// CONFIGURATION
//  DEPTH_NORM_STATS_EN defined: stat_* counters are implemented and saturate at all-ones.
//  DEPTH_NORM_STATS_EN undefined: the stat_* ports still exist, are tied to 0, and no counter logic is
//   built. gap_pulse is present in both builds.
// STRUCTURE
//  binance_depth_types package: depth_event_t, REC_TYPE_DELTA/REC_TYPE_SNAPSHOT, SIDE_BID/SIDE_ASK,
//   FLAG_SNAP=0 and FLAG_GAP=1 bit indices, sync_state_e {UNSYNCED, SYNCED}.
//  Sub-module depth_event_fifo (#(FIFO_DEPTH), element type depth_event_t): sync FIFO exposing full,
//   empty and count.
// TESTING
//  1. Reset, then a delta for sym0 with id=5 -> dropped; out_valid stays 0; stat_drop=1.
//  2. Snapshot sym0 id=100, then deltas id=100 and id=101 -> 3 events out, in order; first has flags=0x01,
//     others flags=0x00; synced[0]=1.
//  3. Synced sym1 at last_uid=10, delta id=15 -> emitted with flags=0x02; gap_pulse high for one cycle;
//     synced[1]=0; a following delta id=16 is dropped.
//  4. Delta id=9 with last_uid=10 -> dropped. in_symbol=NUM_SYMBOLS -> dropped. rec_type=7 -> dropped.
//     stat_drop increments by 3.
//  5. Hold out_ready=0 and push FIFO_DEPTH records -> in_ready=0 and depth_ev stays stable; release
//     out_ready -> all drain in order, no loss or duplication.
//  6. last_uid=64'hFFFF_FFFF_FFFF_FFFF, delta id=0 -> emitted without a gap. Pulse sync_clr -> synced=0.

Source files
------------

// File: rtl/binance_depth_types.sv
// Shared types for the depth-event path: the normalised event record,
// record-type and side encodings, flag bit indices and the per-symbol
// sequence-sync state.
package binance_depth_types;

   localparam logic [7:0] REC_TYPE_DELTA    = 8'd0;
   localparam logic [7:0] REC_TYPE_SNAPSHOT = 8'd1;

   localparam logic SIDE_BID = 1'b0;
   localparam logic SIDE_ASK = 1'b1;

   localparam int FLAG_SNAP = 0;
   localparam int FLAG_GAP  = 1;

   typedef enum logic {
      UNSYNCED = 1'b0,
      SYNCED   = 1'b1
   } sync_state_e;

   typedef struct packed {
      logic [63:0] ts_rx_ns;
      logic [63:0] update_id;
      logic [15:0] symbol_id;
      logic [7:0]  rec_type;
      logic        side;
      logic [7:0]  flags;
      logic [31:0] price_fp;
      logic [31:0] qty_fp;
   } depth_event_t;

   // Builds the flag byte; every bit other than SNAP and GAP stays zero.
   function automatic logic [7:0] event_flags(input logic snap, input logic gap);
      logic [7:0] f;
      f            = 8'h00;
      f[FLAG_SNAP] = snap;
      f[FLAG_GAP]  = gap;
      return f;
   endfunction

endpackage

// File: rtl/depth_event_fifo.sv
// Synchronous FIFO of depth_event_t. DEPTH must be a power of two so the
// pointers wrap naturally. The head reads as zero while the FIFO is empty.
module depth_event_fifo
   import binance_depth_types::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  depth_event_t             push_data,
   input  logic                     pop,
   output depth_event_t             pop_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   depth_event_t   mem [DEPTH];
   logic [AW-1:0]  wr_ptr;
   logic [AW-1:0]  rd_ptr;
   logic [CW-1:0]  cnt;
   logic           do_push;
   logic           do_pop;

   assign full    = (cnt == CW'(DEPTH));
   assign empty   = (cnt == '0);
   assign count   = cnt;
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   // Pointer and occupancy bookkeeping; simultaneous push and pop leave count unchanged.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         if (do_push && !do_pop)      cnt <= cnt + 1'b1;
         else if (do_pop && !do_push) cnt <= cnt - 1'b1;
      end
   end

   // Storage array; contents are don't-care until written, so no reset.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   assign pop_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/depth_event_normalizer.sv
// Multi-symbol depth event normaliser: maps unpacked records to
// depth_event_t, tracks per-symbol sequence sync, drops pre-snapshot and
// stale deltas, flags gaps, and buffers events in an output FIFO.
// Build option: define DEPTH_NORM_STATS_EN to implement the saturating
// stat_* counters; otherwise those ports are tied to zero.
//
// Handshake (both sides): a transfer happens on a rising edge where
// valid && ready are both high. in_ready is !full of the FIFO, whose
// occupancy is a register, so a pop from a full FIFO raises in_ready one
// cycle later. While out_valid && !out_ready the head and out_valid hold.
module depth_event_normalizer
   import binance_depth_types::*;
#(
   parameter int NUM_SYMBOLS = 4,
   parameter int FIFO_DEPTH  = 8,
   parameter int CNT_W       = 32
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [63:0]             in_ts_ns,
   input  logic [63:0]             in_update_id,
   input  logic [15:0]             in_symbol,
   input  logic [7:0]              in_rec_type,
   input  logic [7:0]              in_side,
   input  logic [31:0]             in_price_f32,
   input  logic [31:0]             in_qty_f32,
   input  logic                    sync_clr,
   output logic                    out_valid,
   input  logic                    out_ready,
   output depth_event_t            depth_ev,
   output logic [NUM_SYMBOLS-1:0]  synced,
   output logic                    gap_pulse,
   output logic [CNT_W-1:0]        stat_accept,
   output logic [CNT_W-1:0]        stat_drop,
   output logic [CNT_W-1:0]        stat_gap
);

   localparam int SYM_W = (NUM_SYMBOLS > 1) ? $clog2(NUM_SYMBOLS) : 1;

   // Per-symbol table
   sync_state_e  state_q    [NUM_SYMBOLS];
   logic [63:0]  last_uid_q [NUM_SYMBOLS];

   // Classification of the record currently on the input
   logic              sym_ok;
   logic [SYM_W-1:0]  sym_idx;
   sync_state_e       cur_state;
   sync_state_e       next_state;
   logic [63:0]       cur_uid;
   logic [63:0]       uid_next;
   logic              is_snap;
   logic              is_delta;
   logic              emit;
   logic              is_gap;
   logic              upd;
   depth_event_t      new_ev;

   logic              accept;
   logic              push;
   logic              fifo_full;
   logic              fifo_empty;
   logic [$clog2(FIFO_DEPTH):0] unused_fifo_count;
   logic [6:0]        unused_side;

   assign unused_side = in_side[7:1];
   assign in_ready    = !fifo_full;
   assign out_valid   = !fifo_empty;
   assign accept      = in_valid && in_ready;
   assign push        = accept && emit;

   // Classify the input record against its symbol's {state, last_uid}.
   always_comb begin
      sym_ok     = (in_symbol < 16'(NUM_SYMBOLS));
      sym_idx    = in_symbol[SYM_W-1:0];
      cur_state  = state_q[sym_idx];
      cur_uid    = last_uid_q[sym_idx];
      uid_next   = cur_uid + 64'd1;
      is_snap    = (in_rec_type == REC_TYPE_SNAPSHOT);
      is_delta   = (in_rec_type == REC_TYPE_DELTA);
      emit       = 1'b0;
      is_gap     = 1'b0;
      upd        = 1'b0;
      next_state = cur_state;
      if (sym_ok && is_snap) begin
         emit       = 1'b1;
         upd        = 1'b1;
         next_state = SYNCED;
      end else if (sym_ok && is_delta && (cur_state == SYNCED)) begin
         // Equality to last_uid+1 is tested before the stale check so the
         // wrap from all-ones to zero is accepted.
         if ((in_update_id == cur_uid) || (in_update_id == uid_next)) begin
            emit = 1'b1;
            upd  = 1'b1;
         end else if (in_update_id < cur_uid) begin
            emit = 1'b0;
         end else begin
            emit       = 1'b1;
            upd        = 1'b1;
            is_gap     = 1'b1;
            next_state = UNSYNCED;
         end
      end
   end

   // Assemble the normalised event from the input record.
   always_comb begin
      new_ev           = '0;
      new_ev.ts_rx_ns  = in_ts_ns;
      new_ev.update_id = in_update_id;
      new_ev.symbol_id = in_symbol;
      new_ev.rec_type  = is_snap ? REC_TYPE_SNAPSHOT : REC_TYPE_DELTA;
      new_ev.side      = in_side[0] ? SIDE_ASK : SIDE_BID;
      new_ev.flags     = event_flags(is_snap, is_gap);
      new_ev.price_fp  = in_price_f32;
      new_ev.qty_fp    = in_qty_f32;
   end

   // Per-symbol sync state machine and last-uid table; sync_clr overrides any update.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_SYMBOLS; i++) begin
            state_q[i]    <= UNSYNCED;
            last_uid_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_SYMBOLS; i++) begin
            if (sync_clr) begin
               state_q[i] <= UNSYNCED;
            end else if (accept && upd && (sym_idx == SYM_W'(i))) begin
               state_q[i] <= next_state;
            end
            if (accept && upd && (sym_idx == SYM_W'(i))) begin
               last_uid_q[i] <= in_update_id;
            end
         end
      end
   end

   // Expose the per-symbol SYNCED state.
   always_comb begin
      synced = '0;
      for (int i = 0; i < NUM_SYMBOLS; i++) begin
         synced[i] = (state_q[i] == SYNCED);
      end
   end

   // One-cycle gap pulse, aligned with the gap event becoming visible.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) gap_pulse <= 1'b0;
      else        gap_pulse <= accept && is_gap;
   end

   depth_event_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .push_data (new_ev),
      .pop       (out_ready),
      .pop_data  (depth_ev),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (unused_fifo_count)
   );

`ifdef DEPTH_NORM_STATS_EN
   logic drop;
   assign drop = accept && !emit;

   // Saturating statistics counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_accept <= '0;
         stat_drop   <= '0;
         stat_gap    <= '0;
      end else begin
         if (push && (stat_accept != '1))                stat_accept <= stat_accept + 1'b1;
         if (drop && (stat_drop != '1))                  stat_drop   <= stat_drop + 1'b1;
         if (accept && is_gap && (stat_gap != '1))       stat_gap    <= stat_gap + 1'b1;
      end
   end
`else
   assign stat_accept = '0;
   assign stat_drop   = '0;
   assign stat_gap    = '0;
`endif

endmodule

// File: tb/tb_depth_event_normalizer.sv
// Directed bench for depth_event_normalizer: reset values, snapshot/delta
// sequencing, gap and stale handling, illegal records, full-FIFO hold,
// uid wrap, sync_clr, and mid-stream reset. Stats expectations follow the
// DEPTH_NORM_STATS_EN build option.
module tb_depth_event_normalizer;
   import binance_depth_types::*;

   localparam int NUM_SYMBOLS = 4;
   localparam int FIFO_DEPTH  = 8;
   localparam int CNT_W       = 32;
`ifdef DEPTH_NORM_STATS_EN
   localparam bit STATS_EN = 1'b1;
`else
   localparam bit STATS_EN = 1'b0;
`endif
   localparam int EW = $bits(depth_event_t);

   // Clock and reset
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic                   in_valid = 1'b0;
   logic                   in_ready;
   logic [63:0]            in_ts_ns = '0;
   logic [63:0]            in_update_id = '0;
   logic [15:0]            in_symbol = '0;
   logic [7:0]             in_rec_type = '0;
   logic [7:0]             in_side = '0;
   logic [31:0]            in_price_f32 = '0;
   logic [31:0]            in_qty_f32 = '0;
   logic                   sync_clr = 1'b0;
   logic                   out_valid;
   logic                   out_ready = 1'b1;
   depth_event_t           depth_ev;
   logic [NUM_SYMBOLS-1:0] synced;
   logic                   gap_pulse;
   logic [CNT_W-1:0]       stat_accept;
   logic [CNT_W-1:0]       stat_drop;
   logic [CNT_W-1:0]       stat_gap;

   depth_event_normalizer #(
      .NUM_SYMBOLS (NUM_SYMBOLS),
      .FIFO_DEPTH  (FIFO_DEPTH),
      .CNT_W       (CNT_W)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_ts_ns     (in_ts_ns),
      .in_update_id (in_update_id),
      .in_symbol    (in_symbol),
      .in_rec_type  (in_rec_type),
      .in_side      (in_side),
      .in_price_f32 (in_price_f32),
      .in_qty_f32   (in_qty_f32),
      .sync_clr     (sync_clr),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .depth_ev     (depth_ev),
      .synced       (synced),
      .gap_pulse    (gap_pulse),
      .stat_accept  (stat_accept),
      .stat_drop    (stat_drop),
      .stat_gap     (stat_gap)
   );

   // Scoreboard state
   logic [EW-1:0] exp_q[$];
   int n_checks = 0;
   int n_errors = 0;
   int n_acc    = 0;
   int n_drop   = 0;
   int n_gap    = 0;
   int ts_cnt   = 0;

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [CNT_W-1:0] stat_exp(input int n);
      return STATS_EN ? CNT_W'(n) : '0;
   endfunction

   // Drive one record; emit/flags are the hand-derived expectation for it.
   task automatic send(input logic [15:0] sym, input logic [7:0] rt, input logic [63:0] id,
                       input logic [7:0] side, input logic emit, input logic [7:0] flags);
      depth_event_t ev;
      int n;
      ts_cnt++;
      @(negedge clk);
      in_valid     = 1'b1;
      in_symbol    = sym;
      in_rec_type  = rt;
      in_update_id = id;
      in_side      = side;
      in_ts_ns     = 64'h1000_0000_0000_0000 + 64'(ts_cnt);
      in_price_f32 = 32'h4000_0000 + 32'(ts_cnt);
      in_qty_f32   = 32'h3F80_0000 ^ 32'(ts_cnt * 3);
      n = 0;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) check("in_ready_timeout", in_ready, 1);
      if (emit) begin
         ev           = '0;
         ev.ts_rx_ns  = in_ts_ns;
         ev.update_id = id;
         ev.symbol_id = sym;
         ev.rec_type  = rt;
         ev.side      = side[0];
         ev.flags     = flags;
         ev.price_fp  = in_price_f32;
         ev.qty_fp    = in_qty_f32;
         exp_q.push_back(ev);
         n_acc++;
      end else begin
         n_drop++;
      end
      if (flags[FLAG_GAP]) n_gap++;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || out_valid) && n < 200) begin
         @(posedge clk);
         n++;
      end
      #1;
      check("drain_in_time", n < 200, 1);
   endtask

   task automatic check_stats(input string tag);
      check({tag, "_stat_accept"}, stat_accept, stat_exp(n_acc));
      check({tag, "_stat_drop"},   stat_drop,   stat_exp(n_drop));
      check({tag, "_stat_gap"},    stat_gap,    stat_exp(n_gap));
   endtask

   // Output monitor: every handshaken event must be the next expected one.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         check("ev_expected_present", exp_q.size() != 0, 1);
         if (exp_q.size() != 0) check("ev", depth_ev, exp_q.pop_front());
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      depth_event_t held;

      // Reset
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_depth_ev", depth_ev, 0);
      check("rst_in_ready", in_ready, 1);
      check("rst_synced", synced, 0);
      check("rst_gap_pulse", gap_pulse, 0);
      check_stats("rst");

      // 1: delta before any snapshot is dropped
      send(16'd0, REC_TYPE_DELTA, 64'd5, 8'h00, 1'b0, 8'h00);
      check("t1_out_valid", out_valid, 0);
      @(posedge clk); #1;
      check("t1_out_valid_later", out_valid, 0);
      check("t1_stat_drop", stat_drop, stat_exp(1));

      // 2: snapshot then in-sequence deltas
      send(16'd0, REC_TYPE_SNAPSHOT, 64'd100, 8'h01, 1'b1, 8'h01);
      check("t2_latency_out_valid", out_valid, 1);
      send(16'd0, REC_TYPE_DELTA, 64'd100, 8'hFE, 1'b1, 8'h00);
      send(16'd0, REC_TYPE_DELTA, 64'd101, 8'h03, 1'b1, 8'h00);
      wait_drain();
      check("t2_synced0", synced[0], 1);
      check_stats("t2");

      // 3: gap on sym1
      send(16'd1, REC_TYPE_SNAPSHOT, 64'd10, 8'h00, 1'b1, 8'h01);
      check("t3_synced1_pre", synced[1], 1);
      check("t3_no_gap_on_snap", gap_pulse, 0);
      send(16'd1, REC_TYPE_DELTA, 64'd15, 8'h01, 1'b1, 8'h02);
      check("t3_gap_pulse", gap_pulse, 1);
      check("t3_synced1", synced[1], 0);
      @(posedge clk); #1;
      check("t3_gap_pulse_one_cycle", gap_pulse, 0);
      send(16'd1, REC_TYPE_DELTA, 64'd16, 8'h00, 1'b0, 8'h00);
      check("t3_no_gap_on_drop", gap_pulse, 0);
      wait_drain();
      check_stats("t3");

      // 4: stale, bad symbol, bad rec_type
      send(16'd1, REC_TYPE_SNAPSHOT, 64'd10, 8'h00, 1'b1, 8'h01);
      wait_drain();
      check("t4_drop_before", stat_drop, stat_exp(2));
      send(16'd1, REC_TYPE_DELTA, 64'd9, 8'h00, 1'b0, 8'h00);
      send(16'(NUM_SYMBOLS), REC_TYPE_SNAPSHOT, 64'd500, 8'h00, 1'b0, 8'h00);
      send(16'd0, 8'd7, 64'd102, 8'h00, 1'b0, 8'h00);
      @(posedge clk); #1;
      check("t4_out_valid", out_valid, 0);
      check("t4_drop_after", stat_drop, stat_exp(5));
      check("t4_synced1_kept", synced[1], 1);

      // 5: fill FIFO with consumer stalled, hold, then drain plus one blocked record
      out_ready = 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
         send(16'd0, REC_TYPE_DELTA, 64'd102 + 64'(i), 8'(i), 1'b1, 8'h00);
      end
      check("t5_in_ready_full", in_ready, 0);
      held = depth_ev;
      repeat (3) @(posedge clk);
      #1;
      check("t5_hold_ev", depth_ev, held);
      check("t5_hold_valid", out_valid, 1);
      fork
         send(16'd0, REC_TYPE_DELTA, 64'd110, 8'h01, 1'b1, 8'h00);
         begin
            repeat (2) @(posedge clk);
            #1;
            check("t5_in_ready_still_low", in_ready, 0);
            out_ready = 1'b1;
         end
      join
      wait_drain();
      check("t5_in_ready_after", in_ready, 1);
      check_stats("t5");

      // 6: uid wrap, sync_clr, and sync_clr racing a snapshot
      send(16'd2, REC_TYPE_SNAPSHOT, 64'hFFFF_FFFF_FFFF_FFFF, 8'h01, 1'b1, 8'h01);
      send(16'd2, REC_TYPE_DELTA, 64'd0, 8'h00, 1'b1, 8'h00);
      check("t6_wrap_no_gap", gap_pulse, 0);
      wait_drain();
      check("t6_synced_pre", synced, 4'b0111);
      @(negedge clk); sync_clr = 1'b1;
      @(negedge clk); sync_clr = 1'b0;
      check("t6_sync_clr", synced, 0);
      @(posedge clk); #1;
      sync_clr = 1'b1;
      send(16'd3, REC_TYPE_SNAPSHOT, 64'd50, 8'h00, 1'b1, 8'h01);
      sync_clr = 1'b0;
      check("t6_clr_wins", synced, 0);
      send(16'd3, REC_TYPE_SNAPSHOT, 64'd51, 8'h00, 1'b1, 8'h01);
      check("t6_sym3_synced", synced, 4'b1000);
      wait_drain();
      check_stats("t6");

      // Mid-stream reset
      out_ready = 1'b0;
      send(16'd3, REC_TYPE_DELTA, 64'd52, 8'h00, 1'b1, 8'h00);
      send(16'd3, REC_TYPE_DELTA, 64'd53, 8'h00, 1'b1, 8'h00);
      check("rr_out_valid_pre", out_valid, 1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("rr_out_valid", out_valid, 0);
      check("rr_depth_ev", depth_ev, 0);
      check("rr_in_ready", in_ready, 1);
      check("rr_synced", synced, 0);
      exp_q.delete();
      n_acc = 0; n_drop = 0; n_gap = 0;
      check_stats("rr");
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      send(16'd3, REC_TYPE_DELTA, 64'd54, 8'h00, 1'b0, 8'h00);
      @(posedge clk); #1;
      check("rr_post_drop_valid", out_valid, 0);
      check_stats("rr_post");
      check("final_queue_empty", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
